// File: rtl/argmax_classifier.sv
// argmax_classifier: picks the highest of N_CLASSES signed neuron sums per image, reporting its index and score with a done pulse.
//   clk, rst            : clock, synchronous active-high reset
//   start               : begin/restart an image (clears running max and index counter)
//   in_valid/in_ready   : per-sum handshake, sums arrive in class order
//   in_data             : signed Q4.12 neuron sum
//   bias_data           : signed Q4.12 bias added to in_data (only with ARGMAX_BIAS_ADD_EN)
//   busy, done          : collecting / one-cycle result pulse
//   class_out, max_out  : winning index and score, held until the next done or reset
module argmax_classifier #(
  parameter int N_CLASSES = 10,
  parameter int DATA_W    = 16,
  parameter int FRAC_W    = 12,
  parameter int IDX_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
`ifdef ARGMAX_BIAS_ADD_EN
  input  logic [DATA_W-1:0] bias_data,
`endif
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  class_out,
  output logic [DATA_W-1:0] max_out
);
  if (FRAC_W >= DATA_W || (1 << IDX_W) < N_CLASSES) begin : g_bad_params
    $error("argmax_classifier: inconsistent parameters");
  end
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
  state_t state, state_n;
  logic [IDX_W-1:0] count, run_idx, nxt_idx;
  logic [DATA_W-1:0] run_max, nxt_max, sample;
  logic xfer, take, last;
`ifdef ARGMAX_BIAS_ADD_EN
  logic signed [DATA_W:0] biased;
  assign biased = $signed({in_data[DATA_W-1], in_data}) + $signed({bias_data[DATA_W-1], bias_data});
  // top two bits disagree only on overflow; clamp toward the sign of the true sum
  assign sample = (biased[DATA_W] != biased[DATA_W-1]) ? {biased[DATA_W], {(DATA_W-1){~biased[DATA_W]}}}
                                                       : biased[DATA_W-1:0];
`else
  assign sample = in_data;
`endif
  assign in_ready = state == COLLECT;
  assign busy     = state == COLLECT;
  assign done     = state == DONE;
  // a transfer coinciding with start is dropped because start reinitialises the image
  assign xfer    = in_valid && in_ready && !start;
  assign last    = count == IDX_W'(N_CLASSES - 1);
  assign take    = count == '0 || $signed(sample) > $signed(run_max);
  assign nxt_max = take ? sample : run_max;
  assign nxt_idx = take ? count : run_idx;
  always_comb begin
    state_n = state;
    state_n = (state == COLLECT) ? ((xfer && last) ? DONE : COLLECT)
                                 : (start ? COLLECT : IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      run_max   <= MOST_NEG;
      run_idx   <= '0;
      class_out <= '0;
      max_out   <= '0;
    end else if (start) begin
      count   <= '0;
      run_max <= MOST_NEG;
      run_idx <= '0;
    end else if (xfer) begin
      count   <= count + 1'b1;
      run_max <= nxt_max;
      run_idx <= nxt_idx;
      if (last) begin
        class_out <= nxt_idx;
        max_out   <= nxt_max;
      end
    end
  end
endmodule

// File: tb/tb_argmax_classifier.sv
// tb_argmax_classifier: randomized and directed self-checking bench for argmax_classifier
module tb_argmax_classifier;
  localparam int N = 10;
  logic clk = 0;
  logic rst, start, in_valid;
  logic [15:0] in_data;
`ifdef ARGMAX_BIAS_ADD_EN
  logic [15:0] bias_data;
`endif
  logic in_ready, busy, done;
  logic [3:0] class_out;
  logic [15:0] max_out;
  int passed = 0, total = 0;
  logic [15:0] img [N];
  logic [15:0] bimg [N];
  logic [3:0] prev_cls;
  logic [15:0] prev_max;

  argmax_classifier dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
`ifdef ARGMAX_BIAS_ADD_EN
    .bias_data(bias_data),
`endif
    .in_ready(in_ready), .busy(busy), .done(done), .class_out(class_out), .max_out(max_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_bias(input logic [15:0] b);
`ifdef ARGMAX_BIAS_ADD_EN
    bias_data = b;
`endif
  endtask

  // reference: effective score is the saturated sum; first index holding the maximum wins
  function automatic void model(output logic [3:0] idx, output logic [15:0] mx);
    int best, e;
    best = -100000;
    idx = 0;
    for (int i = 0; i < N; i++) begin
      e = $signed(img[i]) + $signed(bimg[i]);
      if (e > 32767) e = 32767;
      if (e < -32768) e = -32768;
      if (e > best) begin
        best = e;
        idx = 4'(i);
      end
    end
    mx = best[15:0];
  endfunction

  task automatic pulse_start;
    start = 1;
    in_valid = 1;
    in_data = 16'h7FFF;
    set_bias(16'h7FFF);
    step;
    start = 0;
    in_valid = 0;
    chk("start_busy", busy, 1);
    chk("start_ready", in_ready, 1);
  endtask

  task automatic feed(input int n, input bit gaps, output int cyc);
    int i;
    bit ph, ok;
    i = 0;
    cyc = 0;
    ph = 1;
    while (i < n && cyc < 100) begin
      in_valid = gaps ? ph : 1'b1;
      ph = ~ph;
      in_data = img[i];
      set_bias(bimg[i]);
      ok = in_valid && in_ready;
      step;
      cyc++;
      if (ok) i++;
      if (i < N) chk("no_early_done", done, 0);
    end
    in_valid = 0;
    if (cyc >= 100) chk("feed_timeout", 0, 1);
  endtask

  task automatic finish_image(input string tag, input logic [3:0] ei, input logic [15:0] em);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, in_ready, 0);
    chk({tag, "_class"}, class_out, ei);
    chk({tag, "_max"}, max_out, em);
    step;
    chk({tag, "_pulse"}, done, 0);
    chk({tag, "_hold"}, class_out, ei);
    prev_cls = ei;
    prev_max = em;
  endtask

  task automatic run_image(input string tag, input bit gaps, input logic [3:0] ei, input logic [15:0] em);
    int cyc;
    pulse_start;
    feed(N, gaps, cyc);
    chk({tag, "_cycles"}, cyc, gaps ? 19 : 10);
    finish_image(tag, ei, em);
  endtask

  initial begin
    logic [3:0] mi;
    logic [15:0] mm;
    int cyc;
    rst = 1; start = 0; in_valid = 0; in_data = 0;
    set_bias(0);
    for (int i = 0; i < N; i++) bimg[i] = 0;
    step; step;
    rst = 0;
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_class", class_out, 0);
    chk("rst_max", max_out, 0);
    in_valid = 1; in_data = 16'h1234;
    step;
    in_valid = 0;
    chk("idle_ignore_busy", busy, 0);
    chk("idle_ignore_done", done, 0);

    for (int i = 0; i < N; i++) img[i] = 16'h0100;
    img[7] = 16'h2000;
    run_image("peak7", 0, 4'd7, 16'h2000);

    for (int i = 0; i < N; i++) img[i] = 16'hF000;
    run_image("allneg_tie", 0, 4'd0, 16'hF000);

    for (int i = 0; i < N - 1; i++) img[i] = 16'h8000 + 16'(i);
    img[N-1] = 16'h7FFF;
    run_image("extremes", 0, 4'd9, 16'h7FFF);

    for (int i = 0; i < N; i++) img[i] = 16'h0100;
    img[7] = 16'h2000;
    run_image("gaps", 1, 4'd7, 16'h2000);

    for (int i = 0; i < N; i++) img[i] = 16'h7000;
    pulse_start;
    feed(5, 0, cyc);
    pulse_start;
    chk("abort_done", done, 0);
    chk("abort_class_hold", class_out, prev_cls);
    chk("abort_max_hold", max_out, prev_max);
    for (int i = 0; i < N; i++) img[i] = 16'h0400 + 16'(i);
    img[2] = 16'h1800;
    feed(N, 0, cyc);
    chk("abort_cycles", cyc, 10);
    finish_image("abort", 4'd2, 16'h1800);

    for (int t = 0; t < 20; t++) begin
      int mode;
      mode = $urandom_range(0, 2);
      for (int i = 0; i < N; i++) begin
        img[i] = (mode == 0) ? 16'($urandom) : (mode == 1) ? 16'($urandom_range(0, 3))
                                                           : 16'h8000 | 16'($urandom_range(0, 7));
`ifdef ARGMAX_BIAS_ADD_EN
        bimg[i] = (mode == 0) ? 16'($urandom) : 16'($urandom_range(0, 1));
`endif
      end
      model(mi, mm);
      run_image("rand", 1'($urandom_range(0, 1)), mi, mm);
    end

    pulse_start;
    feed(3, 0, cyc);
    rst = 1;
    step;
    rst = 0;
    chk("midrst_done", done, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", in_ready, 0);
    chk("midrst_class", class_out, 0);
    chk("midrst_max", max_out, 0);

    for (int i = 0; i < N; i++) begin
      img[i] = 16'h0000;
      bimg[i] = 16'h0000;
    end
    img[3] = 16'hFFFF;
    run_image("after_rst", 0, 4'd0, 16'h0000);

`ifdef ARGMAX_BIAS_ADD_EN
    for (int i = 0; i < N; i++) begin
      img[i] = 16'h0000;
      bimg[i] = 16'h0000;
    end
    img[4] = 16'h7000;
    bimg[4] = 16'h2000;
    run_image("bias_sat", 0, 4'd4, 16'h7FFF);
    for (int i = 0; i < N; i++) begin
      img[i] = 16'h9000;
      bimg[i] = 16'h9000;
    end
    run_image("bias_negsat", 0, 4'd0, 16'h8000);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
